// File: rtl/debug_brg_pkg.sv
// Shared constants and types for the fractional debug baud rate generator.
package debug_brg_pkg;
    localparam logic [1:0] ADDR_DIV_LO = 2'd0;
    localparam logic [1:0] ADDR_DIV_HI = 2'd1;
    localparam logic [1:0] ADDR_FRAC   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_AB_START = 0;
    localparam int CTRL_AB_CLR   = 1;

    // falling edges of a 0x55 frame after the start edge, spanning 8 bit times
    localparam int SYNC_EDGES = 4;

    typedef enum logic [2:0] {
        AB_IDLE,
        AB_ARM,
        AB_WAIT,
        AB_MEASURE,
        AB_LOAD
    } ab_state_e;
endpackage

// File: rtl/debug_autobaud.sv
// Autobaud: times 8 bit periods of a 0x55 sync char on rx and emits a divisor candidate.
module debug_autobaud
    import debug_brg_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int FRAC_W = 4,
    parameter int AB_W   = CNT_W + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              res_vld,
    output logic              res_err,
    output logic [CNT_W-1:0]  res_int,
    output logic [FRAC_W-1:0] res_frac
);
    logic [1:0]      rx_s;
    logic            rx_d;
    logic            fe;
    ab_state_e       state;
    logic [AB_W-1:0] m;
    logic [2:0]      edges;
    logic [CNT_W-1:0] q_int;

    assign fe    = rx_d & ~rx_s[1];
    assign busy  = (state != AB_IDLE);
    // m spans 8 bit times; m >> (8-FRAC_W) is bit_time/32 with FRAC_W fraction bits
    assign q_int = m[AB_W-1:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s     <= 2'b11;
            rx_d     <= 1'b1;
            state    <= AB_IDLE;
            m        <= '0;
            edges    <= '0;
            res_vld  <= 1'b0;
            res_err  <= 1'b0;
            res_int  <= '0;
            res_frac <= '0;
        end else begin
            rx_s    <= {rx_s[0], rx};
            rx_d    <= rx_s[1];
            res_vld <= 1'b0;
            res_err <= 1'b0;
            if (start) begin
                state <= AB_ARM;
            end else if (abort) begin
                state <= AB_IDLE;
            end else begin
                case (state)
                    AB_ARM: if (rx_s[1]) state <= AB_WAIT;
                    AB_WAIT: if (fe) begin
                        m     <= '0;
                        edges <= '0;
                        state <= AB_MEASURE;
                    end
                    AB_MEASURE: begin
                        if (&m) begin
                            res_vld <= 1'b1;
                            res_err <= 1'b1;
                            state   <= AB_IDLE;
                        end else begin
                            m <= m + 1'b1;
                            if (fe) begin
                                if (edges == 3'(SYNC_EDGES - 1)) state <= AB_LOAD;
                                else edges <= edges + 3'd1;
                            end
                        end
                    end
                    AB_LOAD: begin
                        res_vld <= 1'b1;
                        state   <= AB_IDLE;
                        if (q_int < CNT_W'(2)) begin
                            res_err <= 1'b1;
                        end else begin
                            res_int  <= q_int - 1'b1;
                            res_frac <= m[7:8-FRAC_W];
                        end
                    end
                    default: state <= AB_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/debug_brg_frac.sv
// Debug baud generator with fractional divisor, byte register port and autobaud.
module debug_brg_frac
    import debug_brg_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int FRAC_W    = 4,
    parameter int RESET_DIV = 12,
    parameter int AB_W      = CNT_W + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [1:0]        addr,
    input  logic [7:0]        d,
    input  logic              baud_set,
    input  logic [CNT_W-1:0]  baud_div,
    input  logic              rx,
    output logic              baud_ref,
    output logic              baud_tick,
    output logic [CNT_W-1:0]  div_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              ab_busy,
    output logic              ab_done,
    output logic              ab_err
);
    logic              wr_q;
    logic              wr_edge;
    logic              ctrl_wr;
    logic              ab_start;
    logic              ab_abort;
    logic              res_vld;
    logic              res_err;
    logic [CNT_W-1:0]  res_int;
    logic [FRAC_W-1:0] res_frac;
    logic [CNT_W-1:0]  div;
    logic [FRAC_W-1:0] frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic [CNT_W-1:0]  cnt;

    assign wr_edge  = wr & ~wr_q;
    assign ctrl_wr  = wr_edge && (addr == ADDR_CTRL);
    assign ab_start = ctrl_wr && d[CTRL_AB_START];
    // any register write or direct load cancels a measurement, except the restart itself
    assign ab_abort = ab_busy && (wr_edge ? !ab_start : baud_set);
    assign div_out  = div;
    assign frac_out = frac;
    assign acc_sum  = {1'b0, acc} + {1'b0, frac};

    debug_autobaud #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .AB_W(AB_W)) u_ab (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .start    (ab_start),
        .abort    (ab_abort),
        .busy     (ab_busy),
        .res_vld  (res_vld),
        .res_err  (res_err),
        .res_int  (res_int),
        .res_frac (res_frac)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            div     <= CNT_W'(RESET_DIV);
            frac    <= '0;
            ab_done <= 1'b0;
            ab_err  <= 1'b0;
        end else begin
            wr_q <= wr;
            if (wr_edge) begin
                case (addr)
                    ADDR_DIV_LO: div[7:0]       <= d;
                    ADDR_DIV_HI: div[CNT_W-1:8] <= d[CNT_W-9:0];
                    ADDR_FRAC:   frac           <= d[FRAC_W-1:0];
                    default: if (d[CTRL_AB_START] || d[CTRL_AB_CLR]) begin
                        ab_done <= 1'b0;
                        ab_err  <= 1'b0;
                    end
                endcase
            end else if (baud_set) begin
                div  <= baud_div;
                frac <= '0;
            end else if (res_vld) begin
                if (res_err) begin
                    ab_err <= 1'b1;
                end else begin
                    div     <= res_int;
                    frac    <= res_frac;
                    ab_done <= 1'b1;
                end
            end
        end
    end

    // free-running down counter; divisor changes are picked up at the next reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            baud_ref  <= 1'b0;
            baud_tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt       <= div + CNT_W'(acc_sum[FRAC_W]);
            acc       <= acc_sum[FRAC_W-1:0];
            baud_ref  <= ~baud_ref;
            baud_tick <= 1'b1;
        end else begin
            cnt       <= cnt - 1'b1;
            baud_tick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_debug_brg_frac.sv
// Directed self-checking bench for debug_brg_frac (CNT_W=9, FRAC_W=4).
module tb_debug_brg_frac;
    import debug_brg_pkg::*;

    localparam int CNT_W  = 9;
    localparam int FRAC_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr = 1'b0;
    logic [1:0]        addr = '0;
    logic [7:0]        d = '0;
    logic              baud_set = 1'b0;
    logic [CNT_W-1:0]  baud_div = '0;
    logic              rx = 1'b1;
    logic              baud_ref, baud_tick, ab_busy, ab_done, ab_err;
    logic [CNT_W-1:0]  div_out;
    logic [FRAC_W-1:0] frac_out;

    int n_chk = 0;
    int n_fail = 0;

    debug_brg_frac #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .RESET_DIV(12)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .addr(addr), .d(d),
        .baud_set(baud_set), .baud_div(baud_div), .rx(rx),
        .baud_ref(baud_ref), .baud_tick(baud_tick), .div_out(div_out),
        .frac_out(frac_out), .ab_busy(ab_busy), .ab_done(ab_done), .ab_err(ab_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // clocks until the next baud_tick (bounded; a timeout yields a large count)
    task automatic next_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!baud_tick && n < 2000);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        addr = a;
        d    = v;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    // start bit, 0x55 LSB first, stop bit
    task automatic send_frame(input int bt);
        logic [9:0] bits;
        bits = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (bt) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        int n, p1, p2, total;

        // reset values
        #22;
        chk("rst_tick", baud_tick, 0);
        chk("rst_ref", baud_ref, 0);
        chk("rst_div", div_out, 12);
        chk("rst_frac", frac_out, 0);
        chk("rst_flags", {ab_busy, ab_done, ab_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_tick", baud_tick, 1);
        chk("first_ref", baud_ref, 1);
        next_tick(n);
        chk("period_reset_1", n, 13);
        chk("ref_toggle_1", baud_ref, 0);
        next_tick(n);
        chk("period_reset_2", n, 13);
        chk("ref_toggle_2", baud_ref, 1);
        next_tick(n);
        chk("period_reset_3", n, 13);

        // fractional divisor 4 + 8/16
        wr_reg(ADDR_DIV_LO, 8'd4);
        wr_reg(ADDR_FRAC, 8'd8);
        chk("frac_div", div_out, 4);
        chk("frac_frac", frac_out, 8);
        repeat (3) next_tick(n);
        next_tick(p1);
        next_tick(p2);
        chk("frac_pair_sum", p1 + p2, 11);
        chk("frac_pair_prod", p1 * p2, 30);
        total = 0;
        for (int i = 0; i < 32; i++) begin
            next_tick(n);
            total += n;
        end
        chk("frac_32_ticks", total, 176);

        // direct load alone
        @(negedge clk);
        baud_set = 1'b1;
        baud_div = 9'd6;
        @(negedge clk);
        baud_set = 1'b0;
        chk("bset_div", div_out, 6);
        chk("bset_frac", frac_out, 0);
        wr_reg(ADDR_FRAC, 8'd5);

        // wr held 10 cycles with a concurrent baud_set on the edge cycle
        @(negedge clk);
        addr = ADDR_DIV_LO; d = 8'd7; wr = 1'b1;
        baud_set = 1'b1; baud_div = 9'd3;
        @(negedge clk);
        baud_set = 1'b0;
        d = 8'd5;
        repeat (9) @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        chk("held_wr_div", div_out, 7);
        chk("held_wr_frac", frac_out, 5);

        // autobaud at 320 clk/bit
        wr_reg(ADDR_CTRL, 8'h01);
        chk("ab_busy_start", ab_busy, 1);
        repeat (10) @(negedge clk);
        send_frame(320);
        repeat (5) @(negedge clk);
        chk("ab_ok_done", ab_done, 1);
        chk("ab_ok_err", ab_err, 0);
        chk("ab_ok_busy", ab_busy, 0);
        chk("ab_ok_div", div_out, 9);
        chk("ab_ok_frac", frac_out, 0);
        next_tick(n);
        next_tick(n);
        next_tick(n);
        chk("ab_ok_period", n, 10);

        // rx stuck high after the start edge: measurement saturates
        wr_reg(ADDR_CTRL, 8'h01);
        chk("sat_done_cleared", ab_done, 0);
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (320) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (ab_busy && n < 140000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_busy_timeout", ab_busy, 0);
        @(negedge clk);
        chk("sat_err", ab_err, 1);
        chk("sat_done", ab_done, 0);
        chk("sat_div", div_out, 9);
        wr_reg(ADDR_CTRL, 8'h02);
        chk("clr_err", ab_err, 0);

        // too fast: 40 clk/bit gives integer part 1
        wr_reg(ADDR_CTRL, 8'h01);
        repeat (10) @(negedge clk);
        send_frame(40);
        repeat (5) @(negedge clk);
        chk("fast_err", ab_err, 1);
        chk("fast_done", ab_done, 0);
        chk("fast_busy", ab_busy, 0);
        chk("fast_div", div_out, 9);

        // baud_set aborts mid-measurement
        wr_reg(ADDR_CTRL, 8'h01);
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_busy_before", ab_busy, 1);
        baud_set = 1'b1;
        baud_div = 9'd5;
        @(negedge clk);
        baud_set = 1'b0;
        chk("abort_busy", ab_busy, 0);
        chk("abort_div", div_out, 5);
        chk("abort_frac", frac_out, 0);
        repeat (200) @(negedge clk);
        chk("abort_flags", {ab_done, ab_err}, 0);

        // upper divisor byte
        wr_reg(ADDR_DIV_HI, 8'h01);
        chk("div_hi", div_out, 261);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_div", div_out, 12);
        chk("arst_ref_tick", {baud_ref, baud_tick}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_brg_frac.md
Name: debug_brg_frac

Overview:
- Next-generation debug baud rate generator.
- Adds to the existing design:
  - a parametrised integer divisor;
  - a fractional divisor with a carry accumulator;
  - a byte-wide register write port;
  - hardware autobaud: measures a 0x55 sync character on rx and loads the divisor.
- Sits between the debug CPU bus and the debug UART. baud_ref keeps its existing toggling 16x-reference semantics; baud_tick is new.

Parameters:
- CNT_W, 12, integer divisor/counter width (9..16).
- FRAC_W, 4, fractional divisor width (1..8).
- RESET_DIV, 12, integer divisor after reset.
- AB_W, CNT_W+8, autobaud measurement counter width (fixed derivation).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- wr  in  1  register write strobe, level. Rising edge performs the write.
- addr  in  2  register select: 0=DIV_LO, 1=DIV_HI, 2=FRAC, 3=CTRL.
- d  in  8  write data.
- baud_set  in  1  direct divisor load strobe, level-sampled each cycle.
- baud_div  in  CNT_W  direct divisor value.
- rx  in  1  async serial input, used only by autobaud.
- baud_ref  out  1  toggles at every counter reload.
- baud_tick  out  1  one-cycle pulse at every counter reload.
- div_out  out  CNT_W  current integer divisor.
- frac_out  out  FRAC_W  current fractional divisor.
- ab_busy  out  1  autobaud in progress.
- ab_done  out  1  sticky: autobaud completed OK.
- ab_err  out  1  sticky: autobaud timed out or measured too fast.

Behaviour:
- Reset:
  - div=RESET_DIV, frac=0, acc=0, cnt=0.
  - baud_ref=0, baud_tick=0.
  - autobaud FSM=IDLE; ab_busy=ab_done=ab_err=0.
  - wr edge flop=0; rx synchroniser=11.
- Write decode (register updates on the cycle where wr=1 and the previous wr=0):
  - DIV_LO: div[7:0]=d.
  - DIV_HI: div[CNT_W-1:8]=d[CNT_W-9:0].
  - FRAC: frac=d[FRAC_W-1:0].
  - CTRL: bit0=1 starts autobaud; bit1=1 clears ab_done/ab_err.
- Load priority, highest first: wr edge > baud_set > autobaud result.
  - baud_set loads div=baud_div and frac=0.
  - A wr edge or baud_set while ab_busy aborts autobaud to IDLE, with no flag set.
- Counter:
  - If cnt==0: cnt <= div + carry, where {carry,acc} = acc + frac (FRAC_W+1 bits). Also toggle baud_ref and pulse baud_tick.
  - Otherwise cnt <= cnt-1.
  - Reload period = div+1 (+1 on carry) clocks.
  - Divisor changes take effect at the next reload; the counter is never restarted.
  - div=0 gives a reload every cycle (baud_tick held high).
- rx handling: 2-flop synchroniser, then falling-edge detect (fe = prev & ~cur).
- Autobaud FSM:
  - IDLE: on CTRL bit0, clear ab_done/ab_err and go to ARM.
  - ARM: wait for synchronised rx=1, then go to WAIT.
  - WAIT: on fe, m=0, edges=0, go to MEASURE.
  - MEASURE:
    - m increments each cycle; each fe increments edges.
    - On the 4th fe after the start edge, go to LOAD. This spans 8 bit times of 0x55.
    - If m reaches all-ones, set ab_err and go to IDLE.
  - LOAD (1 cycle): candidate q = m >> (8-FRAC_W), i.e. bit_time/32 in fixed point.
    - If q[AB_W-9+FRAC_W : FRAC_W] < 2: set ab_err.
    - Else: div = q_int - 1 (q_int = integer part of q), frac = q[FRAC_W-1:0], set ab_done.
    - Return to IDLE.
  - ab_busy=1 in ARM, WAIT, MEASURE and LOAD.
  - CTRL bit0 while busy restarts at ARM.
- Reset mid-operation returns everything to reset values within the same cycle (asynchronous).

Decomposition:
- Shared package debug_brg_pkg:
  - register address constants ADDR_DIV_LO/HI/FRAC/CTRL;
  - CTRL bit positions;
  - autobaud state enum (IDLE, ARM, WAIT, MEASURE, LOAD);
  - SYNC_EDGES=4.
- One sub-module: debug_autobaud.
  - Contains the synchroniser, FSM and measurement counter.
  - Outputs a result strobe with the int/frac candidate and the error.
  - Top level owns the registers, priority and counter.

Test Plan:
- Reset, then idle 60 clocks -> div_out=12, frac_out=0. baud_tick every 13 clocks, baud_ref toggles on each tick; first tick on cycle 1 after reset.
- Write DIV_LO=4, FRAC=8 (FRAC_W=4) -> reload periods alternate 5,6,5,6. 32 ticks take exactly 176 clocks.
- wr held high 10 cycles with DIV_LO=7 -> exactly one write. baud_set with baud_div=3 on the same cycle as a wr edge -> div_out=7.
- Autobaud, rx sends 0x55 at 320 clk/bit -> m=2560, q=160: div_out=9, frac_out=0, ab_done=1, ab_busy=0. Subsequent tick period = 10 clocks.
- Autobaud with rx stuck high after start edge -> ab_err=1 when m saturates, div_out unchanged. CTRL bit1 then clears ab_err.
- Autobaud at 40 clk/bit (q_int=1) -> ab_err=1, div unchanged. Separately: baud_set mid-MEASURE -> ab_busy=0, no flags, div_out=baud_div.
